// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
// Shared definitions for the bit-serial adder/subtractor:
//   - state_t : FSM state encoding (IDLE, SHIFT, DONE)
//   - cnt_width() : width of the bit counter for a given operand width
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Counter must index bits 0..w-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_adder.sv
// full_adder
// Single-bit full-adder cell used by the serial datapath.
// Ports:
//   a, b   : operand bits
//   cin    : carry in
//   sum    : a ^ b ^ cin
//   carry  : majority(a, b, cin)
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// serial_adder
// Bit-serial adder/subtractor. Operands are captured on start (in IDLE) and
// processed LSB-first through one full-adder cell, one bit per clock. After
// WIDTH bits the sum, carry-out and signed-overflow flag are registered and
// done pulses for one cycle.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   start       : request, sampled only in IDLE
//   sub         : 0 = a + b + cin, 1 = a - b (cin ignored)
//   cin         : carry-in for add mode
//   a, b        : WIDTH-bit operands
//   busy        : high while bits are being processed (WIDTH cycles)
//   done        : one-cycle result-valid pulse
//   sum         : result register
//   cout        : final carry (sub mode: 1 = no borrow)
//   ovf         : two's-complement overflow
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr_reg;
    logic [WIDTH-1:0] b_sr_reg;
    logic [WIDTH-1:0] s_sr_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;
    logic             cout_reg;
    logic             ovf_reg;
    logic [CW-1:0]    count_reg;
    logic             fa_sum;
    logic             fa_carry;
    logic             last_bit;
    logic [WIDTH-1:0] s_shift;

    full_adder u_full_adder (
        .a     (a_sr_reg[0]),
        .b     (b_sr_reg[0]),
        .cin   (carry_reg),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    assign last_bit = (count_reg == CW'(WIDTH - 1));

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
    assign s_shift = WIDTH'({fa_sum, s_sr_reg} >> 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start)    state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:                  state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr_reg  <= '0;
            b_sr_reg  <= '0;
            s_sr_reg  <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            count_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_sr_reg  <= a;
                        // Subtraction as a + ~b + 1.
                        b_sr_reg  <= sub ? ~b : b;
                        carry_reg <= sub ? 1'b1 : cin;
                        count_reg <= '0;
                    end
                end
                SHIFT: begin
                    a_sr_reg  <= a_sr_reg >> 1;
                    b_sr_reg  <= b_sr_reg >> 1;
                    s_sr_reg  <= s_shift;
                    carry_reg <= fa_carry;
                    count_reg <= count_reg + 1'b1;
                    if (last_bit) begin
                        sum_reg  <= s_shift;
                        cout_reg <= fa_carry;
                        // carry_reg is still the carry into the MSB here.
                        ovf_reg  <= carry_reg ^ fa_carry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_reg == SHIFT);
    assign done = (state_reg == DONE);
    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    logic       clk;
    logic       rst;

    logic       start8, sub8, cin8, busy8, done8, cout8, ovf8;
    logic [7:0] a8, b8, sum8;

    logic       start2, sub2, cin2, busy2, done2, cout2, ovf2;
    logic [1:0] a2, b2, sum2;

    int n_vec;
    int n_err;

    // Expected {ovf, cout, sum[31:0]}
    logic [33:0] q8[$];
    logic [33:0] q2[$];
    logic [33:0] last8;
    logic [33:0] last2;
    int          run8;
    int          run2;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .cin(cin8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .sum(sum8),
        .cout(cout8), .ovf(ovf8)
    );

    serial_adder #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .sub(sub2), .cin(cin2),
        .a(a2), .b(b2), .busy(busy2), .done(done2), .sum(sum2),
        .cout(cout2), .ovf(ovf2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: plain integer arithmetic on w-bit operands.
    function automatic logic [33:0] model(input int w, input logic [31:0] av,
                                          input logic [31:0] bv, input logic cv,
                                          input logic sv);
        longint m;
        longint half;
        longint ua, ub, sa, sb, tot, sr;
        logic [33:0] r;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(av) & m;
        ub   = longint'(bv) & m;
        sa   = (ua >= half) ? ua - (m + 1) : ua;
        sb   = (ub >= half) ? ub - (m + 1) : ub;
        if (sv) begin
            tot = ua + ((m + 1) - ub);   // a - b + 2^w
            sr  = sa - sb;
        end else begin
            tot = ua + ub + longint'(cv);
            sr  = sa + sb + longint'(cv);
        end
        r        = '0;
        r[31:0]  = 32'(tot & m);
        r[32]    = ((tot >> w) & 1) != 0;
        r[33]    = (sr > half - 1) || (sr < -half);
        return r;
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [33:0] e;
        logic [33:0] got;
        if (rst) begin
            run8 = 0;
            run2 = 0;
        end else begin
            n_vec++;
            if (busy8 && done8) begin
                n_err++;
                $display("FAIL busy_done_overlap8 got busy=1 done=1 want not both");
            end
            n_vec++;
            if (busy2 && done2) begin
                n_err++;
                $display("FAIL busy_done_overlap2 got busy=1 done=1 want not both");
            end
            if (busy8) run8++;
            if (busy2) run2++;
            if (done8) begin
                n_vec++;
                if (q8.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_done8 got done=1 want no pulse");
                end else begin
                    e   = q8.pop_front();
                    got = {ovf8, cout8, 24'd0, sum8};
                    if (got !== e) begin
                        n_err++;
                        $display("FAIL result8 got ovf=%0b cout=%0b sum=%h want ovf=%0b cout=%0b sum=%h",
                                 ovf8, cout8, sum8, e[33], e[32], e[7:0]);
                    end
                    n_vec++;
                    if (run8 != 8) begin
                        n_err++;
                        $display("FAIL busy_len8 got %0d want 8", run8);
                    end
                end
                run8 = 0;
            end
            if (done2) begin
                n_vec++;
                if (q2.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_done2 got done=1 want no pulse");
                end else begin
                    e   = q2.pop_front();
                    got = {ovf2, cout2, 30'd0, sum2};
                    if (got !== e) begin
                        n_err++;
                        $display("FAIL result2 got ovf=%0b cout=%0b sum=%h want ovf=%0b cout=%0b sum=%h",
                                 ovf2, cout2, sum2, e[33], e[32], e[1:0]);
                    end
                    n_vec++;
                    if (run2 != 2) begin
                        n_err++;
                        $display("FAIL busy_len2 got %0d want 2", run2);
                    end
                end
                run2 = 0;
            end
        end
    end

    // Issue one operation and wait for its done pulse. With garble set, the
    // operand inputs and start are scrambled while the operation runs.
    task automatic op(input int w, input logic [31:0] av, input logic [31:0] bv,
                      input logic cv, input logic sv, input bit garble);
        int t;
        logic bz, dn;
        logic [33:0] e;
        t = 0;
        while (((w == 8) ? (busy8 | done8) : (busy2 | done2)) && t < 50) begin
            @(negedge clk);
            t++;
        end
        e = model(w, av, bv, cv, sv);
        if (w == 8) begin
            a8 = av[7:0]; b8 = bv[7:0]; cin8 = cv; sub8 = sv; start8 = 1'b1;
            q8.push_back(e); last8 = e;
        end else begin
            a2 = av[1:0]; b2 = bv[1:0]; cin2 = cv; sub2 = sv; start2 = 1'b1;
            q2.push_back(e); last2 = e;
        end
        @(negedge clk);
        bz = (w == 8) ? busy8 : busy2;
        n_vec++;
        if (bz !== 1'b1) begin
            n_err++;
            $display("FAIL accept_busy w=%0d got busy=%0b want 1", w, bz);
        end
        t  = 0;
        dn = (w == 8) ? done8 : done2;
        while (!dn && t < 40) begin
            if (w == 8) begin
                start8 = garble ? 1'($urandom) : 1'b0;
                if (garble) begin
                    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
                end
            end else begin
                start2 = garble ? 1'($urandom) : 1'b0;
                if (garble) begin
                    a2 = 2'($urandom); b2 = 2'($urandom); cin2 = 1'($urandom); sub2 = 1'($urandom);
                end
            end
            @(negedge clk);
            t++;
            dn = (w == 8) ? done8 : done2;
        end
        start8 = 1'b0;
        start2 = 1'b0;
        if (!dn) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout w=%0d got no done want done within bound", w);
        end
        $display("op w=%0d a=%h b=%h cin=%0b sub=%0b -> sum=%h cout=%0b ovf=%0b",
                 w, av, bv, cv, sv, e[31:0], e[32], e[33]);
    endtask

    initial begin
        n_vec = 0; n_err = 0; run8 = 0; run2 = 0;
        last8 = '0; last2 = '0;
        rst = 1'b1;
        start8 = 0; sub8 = 0; cin8 = 0; a8 = '0; b8 = '0;
        start2 = 0; sub2 = 0; cin2 = 0; a2 = '0; b2 = '0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({busy8, done8, cout8, ovf8, sum8, busy2, done2, cout2, ovf2, sum2} !== '0) begin
            n_err++;
            $display("FAIL reset_state got b8=%0b d8=%0b s8=%h b2=%0b d2=%0b s2=%h want all 0",
                     busy8, done8, sum8, busy2, done2, sum2);
        end
        rst = 1'b0;
        @(negedge clk);

        op(8, 32'h5A, 32'h3C, 1'b0, 1'b0, 1'b0);
        op(8, 32'hFF, 32'h01, 1'b0, 1'b0, 1'b0);
        op(8, 32'hFF, 32'h01, 1'b1, 1'b0, 1'b0);
        op(8, 32'h10, 32'h20, 1'b0, 1'b1, 1'b0);
        op(8, 32'h80, 32'h01, 1'b0, 1'b1, 1'b0);
        op(8, 32'h12, 32'h34, 1'b1, 1'b0, 1'b1);

        // Abort mid-operation with reset.
        @(negedge clk);
        a8 = 8'hC3; b8 = 8'h5A; cin8 = 1'b1; sub8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++;
        if ({busy8, done8, cout8, ovf8, sum8} !== '0) begin
            n_err++;
            $display("FAIL reset_abort got busy=%0b done=%0b sum=%h cout=%0b ovf=%0b want all 0",
                     busy8, done8, sum8, cout8, ovf8);
        end
        q8.delete();
        q2.delete();
        last8 = '0; last2 = '0;
        @(negedge clk);
        rst = 1'b0;
        op(8, 32'h33, 32'h44, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            op(8, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
        end

        for (int k = 0; k < 64; k++) begin
            logic [5:0] kv;
            kv = 6'(k);
            op(2, 32'(kv[1:0]), 32'(kv[3:2]), kv[4], kv[5], 1'b0);
            repeat (3) @(negedge clk);
            n_vec++;
            if ({busy2, done2, ovf2, cout2, sum2} !== {1'b0, 1'b0, last2[33], last2[32], last2[1:0]}) begin
                n_err++;
                $display("FAIL hold2 got busy=%0b done=%0b ovf=%0b cout=%0b sum=%h want 0 0 %0b %0b %h",
                         busy2, done2, ovf2, cout2, sum2, last2[33], last2[32], last2[1:0]);
            end
        end

        repeat (5) @(negedge clk);
        n_vec++;
        if (q8.size() != 0 || q2.size() != 0) begin
            n_err++;
            $display("FAIL pending_results got q8=%0d q2=%0d want 0 0", q8.size(), q2.size());
        end
        n_vec++;
        if ({ovf8, cout8, sum8} !== {last8[33], last8[32], last8[7:0]}) begin
            n_err++;
            $display("FAIL hold8 got ovf=%0b cout=%0b sum=%h want %0b %0b %h",
                     ovf8, cout8, sum8, last8[33], last8[32], last8[7:0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
